// File: rtl/attn_seq_pkg.sv
// rtl/attn_seq_pkg.sv - shared inst field positions, clk_en bits and state encoding for attn_seq
package attn_pkg;

  localparam int INST_W = 21;
  localparam int CE_W   = 6;

  localparam int I_PMEM_WR     = 0;
  localparam int I_PMEM_RD     = 1;
  localparam int I_KMEM_WR     = 2;
  localparam int I_KMEM_RD     = 3;
  localparam int I_QMEM_WR     = 4;
  localparam int I_QMEM_RD     = 5;
  localparam int I_MAC_LOAD    = 6;
  localparam int I_MAC_EXEC    = 7;
  localparam int I_PMEM_ADD    = 8;
  localparam int I_QK_ADD      = 12;
  localparam int I_OFIFO_RD    = 16;
  localparam int I_DIV         = 17;
  localparam int I_ACC         = 18;
  localparam int I_FIFO_EXT_RD = 19;
  localparam int I_WRITE_BACK  = 20;

  localparam int CE_ARRAY = 0;
  localparam int CE_OFIFO = 1;
  localparam int CE_QMEM  = 2;
  localparam int CE_KMEM  = 3;
  localparam int CE_PMEM  = 4;
  localparam int CE_SFP   = 5;

  localparam logic [CE_W-1:0] CE_ALL = 6'b111111;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    QWR    = 4'd1,
    KWR    = 4'd2,
    KLOAD  = 4'd3,
    QEXEC  = 4'd4,
    WAIT   = 4'd5,
    OREAD  = 4'd6,
    ACC    = 4'd7,
    DIV_RD = 4'd8,
    DIV_WB = 4'd9,
    DONE   = 4'd10
  } state_t;

  // Core blocks that must be clocked while the sequencer sits in a given state.
  function automatic logic [CE_W-1:0] ce_use(input state_t s);
    logic [CE_W-1:0] m;
    m = '0;
    case (s)
      QWR:   m[CE_QMEM] = 1'b1;
      KWR:   m[CE_KMEM] = 1'b1;
      KLOAD: begin m[CE_KMEM] = 1'b1; m[CE_ARRAY] = 1'b1; end
      QEXEC: begin m[CE_QMEM] = 1'b1; m[CE_ARRAY] = 1'b1; m[CE_OFIFO] = 1'b1; end
      WAIT:  begin m[CE_ARRAY] = 1'b1; m[CE_OFIFO] = 1'b1; end
      OREAD: begin m[CE_OFIFO] = 1'b1; m[CE_PMEM] = 1'b1; end
      ACC, DIV_RD, DIV_WB: begin m[CE_PMEM] = 1'b1; m[CE_SFP] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/attn_seq_cnt.sv
// rtl/attn_seq_cnt.sv - loadable 4-bit row/wait counter with terminal flag
module attn_seq_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       inc,
  input  logic [3:0] last_val,
  output logic [3:0] cnt,
  output logic       term
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign term = (cnt == last_val);

endmodule

// File: rtl/attn_seq.sv
// rtl/attn_seq.sv - attention core sequencer FSM; define ATTN_SEQ_CLK_GATE_EN for per-block clk_en gating
module attn_seq
  import attn_pkg::*;
#(
  parameter int col        = 8,
  parameter int DRAIN_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          q_len_m1,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [INST_W-1:0]   inst,
  output logic [CE_W-1:0]     clk_en,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] K_LAST     = 4'(col - 1);
  localparam logic [3:0] KLOAD_LAST = 4'(col);
  localparam logic [3:0] WAIT_LAST  = 4'(DRAIN_WAIT - 1);

  state_t            state, next_state;
  logic [3:0]        n_m1;
  logic [3:0]        cnt;
  logic [3:0]        term_val;
  logic              cnt_term;
  logic              advance;
  logic              cnt_load;
  logic              accept;
  logic [INST_W-1:0] inst_d;

  assign accept = in_ready & in_valid;

  always_comb begin
    term_val = '0;
    case (state)
      QWR, QEXEC, OREAD, ACC, DIV_RD, DIV_WB: term_val = n_m1;
      KWR:   term_val = K_LAST;
      KLOAD: term_val = KLOAD_LAST;
      WAIT:  term_val = WAIT_LAST;
      default: term_val = '0;
    endcase
  end

  attn_seq_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .inc      (advance),
    .last_val (term_val),
    .cnt      (cnt),
    .term     (cnt_term)
  );

  // One counter serves every phase; it restarts at 0 whenever a phase is left.
  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      IDLE:   if (start) next_state = QWR;
      QWR:    begin advance = accept; if (accept && cnt_term) next_state = KWR; end
      KWR:    begin advance = accept; if (accept && cnt_term) next_state = KLOAD; end
      KLOAD:  begin advance = 1'b1; if (cnt_term) next_state = QEXEC; end
      QEXEC:  begin advance = 1'b1; if (cnt_term) next_state = WAIT; end
      WAIT:   begin advance = 1'b1; if (cnt_term) next_state = OREAD; end
      OREAD:  begin advance = 1'b1; if (cnt_term) next_state = ACC; end
      ACC:    begin advance = 1'b1; if (cnt_term) next_state = DIV_RD; end
      DIV_RD: next_state = DIV_WB;
      DIV_WB: begin advance = 1'b1; next_state = cnt_term ? DONE : DIV_RD; end
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    cnt_load = (state == IDLE) || (state == DONE) || (advance && cnt_term);
  end

  always_comb begin
    inst_d = '0;
    case (state)
      QWR: if (accept) begin
        inst_d[I_QMEM_WR]        = 1'b1;
        inst_d[I_QK_ADD +: 4]    = cnt;
      end
      KWR: if (accept) begin
        inst_d[I_KMEM_WR]        = 1'b1;
        inst_d[I_QK_ADD +: 4]    = cnt;
      end
      KLOAD: begin
        inst_d[I_MAC_LOAD]       = 1'b1;
        if (!cnt_term) begin
          inst_d[I_KMEM_RD]      = 1'b1;
          inst_d[I_QK_ADD +: 4]  = cnt;
        end
      end
      QEXEC: begin
        inst_d[I_MAC_EXEC]       = 1'b1;
        inst_d[I_QMEM_RD]        = 1'b1;
        inst_d[I_QK_ADD +: 4]    = cnt;
      end
      OREAD: begin
        inst_d[I_OFIFO_RD]       = 1'b1;
        inst_d[I_PMEM_WR]        = 1'b1;
        inst_d[I_PMEM_ADD +: 4]  = cnt;
      end
      ACC: begin
        inst_d[I_PMEM_RD]        = 1'b1;
        inst_d[I_ACC]            = 1'b1;
        inst_d[I_PMEM_ADD +: 4]  = cnt;
      end
      DIV_RD: begin
        inst_d[I_PMEM_RD]        = 1'b1;
        inst_d[I_DIV]            = 1'b1;
        inst_d[I_FIFO_EXT_RD]    = 1'b1;
        inst_d[I_PMEM_ADD +: 4]  = cnt;
      end
      DIV_WB: begin
        inst_d[I_PMEM_WR]        = 1'b1;
        inst_d[I_WRITE_BACK]     = 1'b1;
        inst_d[I_PMEM_ADD +: 4]  = cnt;
      end
      default: inst_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n_m1     <= '0;
      inst     <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      if (state == IDLE && start) n_m1 <= q_len_m1;
      inst     <= inst_d;
      done     <= (state == DONE);
      busy     <= (state != IDLE);
      in_ready <= (next_state == QWR) || (next_state == KWR);
    end
  end

`ifdef ATTN_SEQ_CLK_GATE_EN
  logic [CE_W-1:0] ce_prev;

  // Each block stays enabled for one trailing cycle after its last use.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_prev <= CE_ALL;
      clk_en  <= CE_ALL;
    end else begin
      ce_prev <= ce_use(state);
      clk_en  <= ce_use(state) | ce_prev;
    end
  end
`else
  always_ff @(posedge clk) begin
    clk_en <= CE_ALL;
  end
`endif

endmodule

// File: tb/tb_attn_seq.sv
// tb/tb_attn_seq.sv - directed self-checking bench for attn_seq
module tb_attn_seq;

  localparam int COL   = 8;
  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  q_len_m1;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] inst;
  logic [5:0]  clk_en;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;
  int done_t;

  attn_seq #(.col(COL), .DRAIN_WAIT(DRAIN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .q_len_m1 (q_len_m1),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst     (inst),
    .clk_en   (clk_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected inst t edges after the start edge, with in_valid held high.
  function automatic logic [20:0] exp_inst(input int t, input int n);
    logic [20:0] r;
    int p;
    r = '0;
    p = t;
    if (p < 1) return r;
    if (p <= n) begin r[4] = 1'b1; r[15:12] = 4'(p - 1); return r; end
    p -= n;
    if (p <= COL) begin r[2] = 1'b1; r[15:12] = 4'(p - 1); return r; end
    p -= COL;
    if (p <= COL + 1) begin
      r[6] = 1'b1;
      if (p <= COL) begin r[3] = 1'b1; r[15:12] = 4'(p - 1); end
      return r;
    end
    p -= COL + 1;
    if (p <= n) begin r[7] = 1'b1; r[5] = 1'b1; r[15:12] = 4'(p - 1); return r; end
    p -= n;
    if (p <= DRAIN) return r;
    p -= DRAIN;
    if (p <= n) begin r[16] = 1'b1; r[0] = 1'b1; r[11:8] = 4'(p - 1); return r; end
    p -= n;
    if (p <= n) begin r[1] = 1'b1; r[18] = 1'b1; r[11:8] = 4'(p - 1); return r; end
    p -= n;
    if (p <= 2 * n) begin
      if (p % 2 == 1) begin r[1] = 1'b1; r[17] = 1'b1; r[19] = 1'b1; end
      else            begin r[0] = 1'b1; r[20] = 1'b1; end
      r[11:8] = 4'((p - 1) / 2);
      return r;
    end
    return r;
  endfunction

  task automatic run_full(input int n);
    int tdone;
    tdone  = 6 * n + 2 * COL + DRAIN + 2;
    done_t = -1;
    q_len_m1 = 4'(n - 1);
    in_valid = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("ready_at_start", in_ready, 1);
    chk("busy_at_start", busy, 0);
    for (int t = 1; t <= tdone + 1; t++) begin
      start = (t == 20);
      step();
      start = 1'b0;
      if (done && done_t < 0) done_t = t;
      chk($sformatf("inst n=%0d t=%0d", n, t), inst, exp_inst(t, n));
      chk($sformatf("done n=%0d t=%0d", n, t), done, (t == tdone));
      chk($sformatf("busy n=%0d t=%0d", n, t), busy, (t <= tdone));
      chk($sformatf("ready n=%0d t=%0d", n, t), in_ready, (t < n + COL));
      chk($sformatf("pmem_rdwr t=%0d", t), inst[0] & inst[1], 0);
`ifdef ATTN_SEQ_CLK_GATE_EN
      if (n > 1 && t == 2 * n + 2 * COL + DRAIN + 3) chk("ce_oread", clk_en, 6'b010010);
      if (t == tdone + 1) chk("ce_idle", clk_en, 0);
`else
      chk($sformatf("ce_const t=%0d", t), clk_en, 6'h3f);
`endif
    end
  endtask

  logic [20:0] tog_exp [8];
  logic        seen;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    q_len_m1 = 4'd0;
    step();
    step();
    chk("rst_inst", inst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_clk_en", clk_en, 6'h3f);
    reset = 1'b0;
    step();

    run_full(8);
    chk("done_latency_8", done_t, 70);
    run_full(16);
    chk("done_latency_16", done_t, 118);
    run_full(1);
    chk("done_latency_1", done_t, 28);

    // in_valid toggling in QWR with N=4: writes only on valid cycles, rows 0..3
    tog_exp[0] = 21'h00010; tog_exp[1] = 21'h0;
    tog_exp[2] = 21'h01010; tog_exp[3] = 21'h0;
    tog_exp[4] = 21'h02010; tog_exp[5] = 21'h0;
    tog_exp[6] = 21'h03010; tog_exp[7] = 21'h0;
    q_len_m1 = 4'd3;
    in_valid = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      in_valid = (t % 2 == 1);
      step();
      chk($sformatf("tog_inst t=%0d", t), inst, tog_exp[t-1]);
      chk($sformatf("tog_ready t=%0d", t), in_ready, 1);
    end
    in_valid = 1'b1;
    step();
    chk("tog_kwr_first", inst, 21'h00004);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done) begin seen = 1'b1; break; end
      chk("tog_pmem_rdwr", inst[0] & inst[1], 0);
    end
    chk("tog_done_seen", seen, 1);
    step();
    step();

    // reset in the middle of QEXEC
    q_len_m1 = 4'd7;
    in_valid = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 28; t++) step();
    chk("pre_rst_qexec", inst, 21'h020a0);
    reset = 1'b1;
    step();
    chk("mid_rst_inst", inst, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    step();
    run_full(8);
    chk("restart_latency", done_t, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
